// File: rtl/gpr_write_scheduler_pkg.sv
// Shared register-file writeback types: MIPS register index, writeback request record.
package gpr_write_scheduler_pkg;

  typedef logic [4:0] MipsReg;

  localparam MipsReg ZERO      = 5'd0;
  localparam int     GPR_COUNT = 32;

  typedef struct packed {
    MipsReg      addr;
    logic [31:0] data;
    logic [31:0] pc;
  } WbReq;

endpackage

// File: rtl/gpr_wb_fifo.sv
// Synchronous FIFO of WbReq with show-ahead head; pushes at full and pops at empty are dropped.
module gpr_wb_fifo
  import gpr_write_scheduler_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  WbReq                   push_data,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output WbReq                   head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;

  WbReq          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gpr_write_scheduler.sv
// Maps pipe writebacks onto the two GPR write ports and fills idle ports from buffered long-latency results.
// One cycle from request to registered port outputs; lat_ready drops while the result FIFO is full.
module gpr_write_scheduler
  import gpr_write_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb0_valid,
  input  MipsReg               wb0_addr,
  input  logic [XLEN-1:0]      wb0_data,
  input  logic [XLEN-1:0]      wb0_pc,
  input  logic                 wb1_valid,
  input  MipsReg               wb1_addr,
  input  logic [XLEN-1:0]      wb1_data,
  input  logic [XLEN-1:0]      wb1_pc,
  input  logic                 lat_valid,
  output logic                 lat_ready,
  input  MipsReg               lat_addr,
  input  logic [XLEN-1:0]      lat_data,
  input  logic [XLEN-1:0]      lat_pc,
  input  logic                 lat_alloc,
  input  MipsReg               lat_alloc_addr,
  output logic [GPR_COUNT-1:0] busy_mask,
  output logic                 reg_write0,
  output MipsReg               write_addr0,
  output logic [XLEN-1:0]      write_data0,
  output logic [XLEN-1:0]      pc0,
  output logic                 reg_write1,
  output MipsReg               write_addr1,
  output logic [XLEN-1:0]      write_data1,
  output logic [XLEN-1:0]      pc1
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = FIFO_DEPTH[CW-1:0];

  WbReq                 lat_req;
  WbReq                 head;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic                 push;
  logic                 pop;
  logic                 head_collide;
  logic                 grant0;
  logic                 grant1;
  logic [GPR_COUNT-1:0] busy_next;

  assign lat_req   = '{addr: lat_addr, data: lat_data, pc: lat_pc};
  assign lat_ready = !rst && (count < DEPTH_CNT);
  assign push      = lat_valid && !full && !rst;

  // Never let a buffered result land on the same register as a pipe write in the same cycle.
  assign head_collide = (head.addr != ZERO) &&
                        ((wb0_valid && (wb0_addr == head.addr)) ||
                         (wb1_valid && (wb1_addr == head.addr)));
  assign grant1 = !empty && !head_collide && !wb1_valid;
  assign grant0 = !empty && !head_collide && wb1_valid && !wb0_valid;
  assign pop    = grant0 || grant1;

  gpr_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (lat_req),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .count     (count)
  );

  // A new allocation outranks the retiring write to the same register.
  always_comb begin
    busy_next = busy_mask;
    if (pop && (head.addr != ZERO)) busy_next[head.addr] = 1'b0;
    if (lat_alloc && (lat_alloc_addr != ZERO)) busy_next[lat_alloc_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write0  <= 1'b0;
      write_addr0 <= ZERO;
      write_data0 <= '0;
      pc0         <= '0;
      reg_write1  <= 1'b0;
      write_addr1 <= ZERO;
      write_data1 <= '0;
      pc1         <= '0;
      busy_mask   <= '0;
    end else begin
      if (wb0_valid) begin
        reg_write0  <= (wb0_addr != ZERO);
        write_addr0 <= wb0_addr;
        write_data0 <= wb0_data;
        pc0         <= wb0_pc;
      end else if (grant0) begin
        reg_write0  <= (head.addr != ZERO);
        write_addr0 <= head.addr;
        write_data0 <= head.data;
        pc0         <= head.pc;
      end else begin
        reg_write0  <= 1'b0;
        write_addr0 <= ZERO;
        write_data0 <= '0;
        pc0         <= '0;
      end
      if (wb1_valid) begin
        reg_write1  <= (wb1_addr != ZERO);
        write_addr1 <= wb1_addr;
        write_data1 <= wb1_data;
        pc1         <= wb1_pc;
      end else if (grant1) begin
        reg_write1  <= (head.addr != ZERO);
        write_addr1 <= head.addr;
        write_data1 <= head.data;
        pc1         <= head.pc;
      end else begin
        reg_write1  <= 1'b0;
        write_addr1 <= ZERO;
        write_data1 <= '0;
        pc1         <= '0;
      end
      busy_mask <= busy_next;
    end
  end

endmodule

// File: tb/tb_gpr_write_scheduler.sv
// Directed scenarios plus a randomized run against a queue-based reference model of the scheduler.
module tb_gpr_write_scheduler;
  import gpr_write_scheduler_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb0_valid = 0, wb1_valid = 0, lat_valid = 0, lat_alloc = 0;
  logic [4:0]  wb0_addr = 0, wb1_addr = 0, lat_addr = 0, lat_alloc_addr = 0;
  logic [31:0] wb0_data = 0, wb0_pc = 0, wb1_data = 0, wb1_pc = 0, lat_data = 0, lat_pc = 0;
  logic        lat_ready, reg_write0, reg_write1;
  logic [31:0] busy_mask;
  logic [4:0]  write_addr0, write_addr1;
  logic [31:0] write_data0, pc0, write_data1, pc1;

  int checks = 0;
  int errors = 0;

  gpr_write_scheduler #(.FIFO_DEPTH(DEPTH), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_pc(wb0_pc),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_pc(wb1_pc),
    .lat_valid(lat_valid), .lat_ready(lat_ready), .lat_addr(lat_addr), .lat_data(lat_data),
    .lat_pc(lat_pc), .lat_alloc(lat_alloc), .lat_alloc_addr(lat_alloc_addr),
    .busy_mask(busy_mask),
    .reg_write0(reg_write0), .write_addr0(write_addr0), .write_data0(write_data0), .pc0(pc0),
    .reg_write1(reg_write1), .write_addr1(write_addr1), .write_data1(write_data1), .pc1(pc1)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending results and a set of busy registers.
  WbReq        q[$];
  WbReq        m_head, m_new;
  logic [31:0] m_busy = 0;
  logic        m_we0 = 0, m_we1 = 0;
  logic [4:0]  m_a0 = 0, m_a1 = 0;
  logic [31:0] m_d0 = 0, m_d1 = 0, m_p0 = 0, m_p1 = 0;
  bit          m_room, m_g0, m_g1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_busy = 0;
      m_we0 = 0;
      m_we1 = 0;
    end else begin
      m_room = (q.size() < DEPTH);
      m_g0 = 0;
      m_g1 = 0;
      if (q.size() > 0) begin
        m_head = q[0];
        if (!(m_head.addr != 0 && ((wb0_valid && wb0_addr == m_head.addr) ||
                                   (wb1_valid && wb1_addr == m_head.addr)))) begin
          if (!wb1_valid) m_g1 = 1;
          else if (!wb0_valid) m_g0 = 1;
        end
      end
      if (wb0_valid) begin
        m_we0 = (wb0_addr != 0); m_a0 = wb0_addr; m_d0 = wb0_data; m_p0 = wb0_pc;
      end else if (m_g0) begin
        m_we0 = (m_head.addr != 0); m_a0 = m_head.addr; m_d0 = m_head.data; m_p0 = m_head.pc;
      end else m_we0 = 0;
      if (wb1_valid) begin
        m_we1 = (wb1_addr != 0); m_a1 = wb1_addr; m_d1 = wb1_data; m_p1 = wb1_pc;
      end else if (m_g1) begin
        m_we1 = (m_head.addr != 0); m_a1 = m_head.addr; m_d1 = m_head.data; m_p1 = m_head.pc;
      end else m_we1 = 0;
      if (m_g0 || m_g1) begin
        if (m_head.addr != 0) m_busy[m_head.addr] = 1'b0;
        void'(q.pop_front());
      end
      if (lat_alloc && lat_alloc_addr != 0) m_busy[lat_alloc_addr] = 1'b1;
      if (lat_valid && m_room) begin
        m_new.addr = lat_addr; m_new.data = lat_data; m_new.pc = lat_pc;
        q.push_back(m_new);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb0_valid = 0; wb1_valid = 0; lat_valid = 0; lat_alloc = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({reg_write0, reg_write1} !== 2'b00) begin
      errors++; $display("FAIL reset_we: got %b want 00", {reg_write0, reg_write1});
    end
    checks++;
    if ({write_addr0, write_data0, pc0, write_addr1, write_data1, pc1} !== '0) begin
      errors++; $display("FAIL reset_ports: got a0=%0d d0=%h a1=%0d d1=%h want all 0",
                         write_addr0, write_data0, write_addr1, write_data1);
    end
    checks++;
    if (lat_ready !== 1'b0 || busy_mask !== 32'h0) begin
      errors++; $display("FAIL reset_ready_busy: got ready=%b busy=%h want 0/0", lat_ready, busy_mask);
    end
    rst = 0;
    // Load one buffered $9 and a pending bit while both pipes write.
    wb0_valid = 1; wb0_addr = 3; wb0_data = 32'h33; wb0_pc = 32'h100;
    wb1_valid = 1; wb1_addr = 4; wb1_data = 32'h44; wb1_pc = 32'h104;
    lat_alloc = 1; lat_alloc_addr = 9;
    lat_valid = 1; lat_addr = 9; lat_data = 32'h99; lat_pc = 32'h200;
    tick();
    lat_alloc = 0; lat_valid = 0;
    tick();
    checks++;
    if (busy_mask !== 32'h200 || reg_write0 !== 1'b1) begin
      errors++; $display("FAIL midop_pre: got busy=%h we0=%b want 200/1", busy_mask, reg_write0);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({reg_write0, reg_write1} !== 2'b00 || busy_mask !== 32'h0 || lat_ready !== 1'b0) begin
      errors++; $display("FAIL midop_reset: got we=%b busy=%h ready=%b want 00/0/0",
                         {reg_write0, reg_write1}, busy_mask, lat_ready);
    end
    @(negedge clk);
    idle_inputs();
    rst = 0;
    tick();
    checks++;
    if (lat_ready !== 1'b1) begin
      errors++; $display("FAIL release_ready: got %b want 1", lat_ready);
    end
    checks++;
    if ({reg_write0, reg_write1} !== 2'b00 || busy_mask !== 32'h0) begin
      errors++; $display("FAIL release_stale: got we=%b busy=%h want 00/0", {reg_write0, reg_write1}, busy_mask);
    end
    tick();
    checks++;
    if (reg_write1 !== 1'b0) begin
      errors++; $display("FAIL release_stale2: got we1=%b want 0", reg_write1);
    end
  endtask

  task automatic test_dual_pipe();
    wb0_valid = 1; wb0_addr = 5; wb0_data = 32'h11; wb0_pc = 32'h0040_0000;
    wb1_valid = 1; wb1_addr = 6; wb1_data = 32'h22; wb1_pc = 32'h0040_0004;
    tick();
    idle_inputs();
    checks++;
    if ({reg_write0, write_addr0, write_data0, pc0} !== {1'b1, 5'd5, 32'h11, 32'h0040_0000}) begin
      errors++; $display("FAIL dual_port0: got we=%b a=%0d d=%h pc=%h want 1/5/11/00400000",
                         reg_write0, write_addr0, write_data0, pc0);
    end
    checks++;
    if ({reg_write1, write_addr1, write_data1, pc1} !== {1'b1, 5'd6, 32'h22, 32'h0040_0004}) begin
      errors++; $display("FAIL dual_port1: got we=%b a=%0d d=%h pc=%h want 1/6/22/00400004",
                         reg_write1, write_addr1, write_data1, pc1);
    end
    tick();
  endtask

  task automatic test_deferred_drain();
    lat_alloc = 1; lat_alloc_addr = 9;
    tick();
    lat_alloc = 0;
    checks++;
    if (busy_mask !== 32'h200) begin
      errors++; $display("FAIL drain_alloc: got busy=%h want 200", busy_mask);
    end
    wb0_valid = 1; wb0_addr = 1; wb0_data = 32'h1; wb0_pc = 32'h10;
    wb1_valid = 1; wb1_addr = 2; wb1_data = 32'h2; wb1_pc = 32'h14;
    lat_valid = 1; lat_addr = 9; lat_data = 32'hDEAD_BEEF; lat_pc = 32'h0040_0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      lat_valid = 0;
      checks++;
      if (busy_mask !== 32'h200 || write_addr1 !== 5'd2 || write_addr0 !== 5'd1) begin
        errors++; $display("FAIL drain_hold%0d: got busy=%h a0=%0d a1=%0d want 200/1/2",
                           c, busy_mask, write_addr0, write_addr1);
      end
    end
    wb1_valid = 0;
    tick();
    idle_inputs();
    checks++;
    if ({reg_write1, write_addr1, write_data1, pc1} !== {1'b1, 5'd9, 32'hDEAD_BEEF, 32'h0040_0100}) begin
      errors++; $display("FAIL drain_grant: got we=%b a=%0d d=%h pc=%h want 1/9/deadbeef/00400100",
                         reg_write1, write_addr1, write_data1, pc1);
    end
    checks++;
    if (busy_mask !== 32'h0) begin
      errors++; $display("FAIL drain_clear: got busy=%h want 0", busy_mask);
    end
    tick();
  endtask

  task automatic test_full_fifo();
    wb0_valid = 1; wb0_addr = 1; wb1_valid = 1; wb1_addr = 2;
    lat_valid = 1; lat_addr = 10; lat_data = 32'hA0; lat_pc = 32'h300;
    tick();
    lat_addr = 11; lat_data = 32'hB0; lat_pc = 32'h304;
    tick();
    checks++;
    if (lat_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready: got %b want 0", lat_ready);
    end
    lat_addr = 12; lat_data = 32'hC0; lat_pc = 32'h308;
    tick();
    idle_inputs();
    tick();
    checks++;
    if ({reg_write1, write_addr1, write_data1} !== {1'b1, 5'd10, 32'hA0}) begin
      errors++; $display("FAIL full_pop10: got we=%b a=%0d d=%h want 1/10/a0", reg_write1, write_addr1, write_data1);
    end
    checks++;
    if (lat_ready !== 1'b1) begin
      errors++; $display("FAIL full_ready_back: got %b want 1", lat_ready);
    end
    tick();
    checks++;
    if ({reg_write1, write_addr1, write_data1} !== {1'b1, 5'd11, 32'hB0}) begin
      errors++; $display("FAIL full_pop11: got we=%b a=%0d d=%h want 1/11/b0", reg_write1, write_addr1, write_data1);
    end
    tick();
    checks++;
    if ({reg_write0, reg_write1} !== 2'b00) begin
      errors++; $display("FAIL full_no12: got we=%b want 00", {reg_write0, reg_write1});
    end
  endtask

  task automatic test_zero_collision();
    wb0_valid = 1; wb0_addr = 0; wb0_data = 32'h55;
    tick();
    wb0_valid = 0;
    checks++;
    if (reg_write0 !== 1'b0) begin
      errors++; $display("FAIL zero_wb0: got we0=%b want 0", reg_write0);
    end
    lat_alloc = 1; lat_alloc_addr = 9;
    tick();
    wb0_valid = 1; wb0_addr = 1; wb1_valid = 1; wb1_addr = 2;
    lat_alloc = 0;
    lat_valid = 1; lat_addr = 9; lat_data = 32'h9999; lat_pc = 32'h400;
    tick();
    lat_valid = 0;
    lat_alloc = 1; lat_alloc_addr = 0;
    tick();
    checks++;
    if (busy_mask !== 32'h200) begin
      errors++; $display("FAIL zero_alloc: got busy=%h want 200", busy_mask);
    end
    wb1_valid = 0; lat_alloc_addr = 9;
    tick();
    idle_inputs();
    checks++;
    if ({reg_write1, write_addr1, write_data1} !== {1'b1, 5'd9, 32'h9999} || busy_mask[9] !== 1'b1) begin
      errors++; $display("FAIL set_wins: got we1=%b a1=%0d d1=%h busy=%h want 1/9/9999/bit9 set",
                         reg_write1, write_addr1, write_data1, busy_mask);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      wb0_valid = ($urandom_range(0, 2) != 0); wb0_addr = 5'($urandom_range(0, 7));
      wb0_data = $urandom; wb0_pc = $urandom;
      wb1_valid = ($urandom_range(0, 1) != 0); wb1_addr = 5'($urandom_range(0, 7));
      wb1_data = $urandom; wb1_pc = $urandom;
      lat_valid = ($urandom_range(0, 1) != 0); lat_addr = 5'($urandom_range(0, 7));
      lat_data = $urandom; lat_pc = $urandom;
      lat_alloc = ($urandom_range(0, 3) == 0); lat_alloc_addr = 5'($urandom_range(0, 31));
      checks++;
      if (lat_ready !== (q.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, lat_ready, q.size() < DEPTH);
      end
      tick();
      checks++;
      if (reg_write0 !== m_we0 || (m_we0 && {write_addr0, write_data0, pc0} !== {m_a0, m_d0, m_p0})) begin
        errors++; $display("FAIL rnd_port0[%0d]: got %b/%0d/%h/%h want %b/%0d/%h/%h", i,
                           reg_write0, write_addr0, write_data0, pc0, m_we0, m_a0, m_d0, m_p0);
      end
      checks++;
      if (reg_write1 !== m_we1 || (m_we1 && {write_addr1, write_data1, pc1} !== {m_a1, m_d1, m_p1})) begin
        errors++; $display("FAIL rnd_port1[%0d]: got %b/%0d/%h/%h want %b/%0d/%h/%h", i,
                           reg_write1, write_addr1, write_data1, pc1, m_we1, m_a1, m_d1, m_p1);
      end
      checks++;
      if (busy_mask !== m_busy) begin
        errors++; $display("FAIL rnd_busy[%0d]: got %h want %h", i, busy_mask, m_busy);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_dual_pipe();
    test_deferred_drain();
    test_full_fifo();
    test_zero_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
